// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared encodings for the RAM port arbiter: FSM states,
//                access size codes and requester (owner) codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Arbiter FSM states
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_ERR    = 2'b10;
    localparam logic [1:0] ST_RESP   = 2'b11;

    // Access size codes (2'b11 is illegal)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Requester identities
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_lane_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_decode
//  Description : Combinational byte-lane decoder. Maps an access size and the
//                low two address bits to RAM byte enables and flags
//                misaligned or illegal-size accesses.
//  Ports       : size    - access size code (SZ_*)
//                addr_lo - address bits [1:0]
//                be      - byte enables, lane 0 = bits [7:0]
//                illegal - 1 when the access cannot be performed
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_decode
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] be,
    output logic       illegal
);

    always_comb begin
        be      = 4'b0000;
        illegal = 1'b0;
        case (size)
            SZ_BYTE: begin
                be = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                be      = 4'b0011 << addr_lo;
                illegal = addr_lo[0];
            end
            SZ_WORD: begin
                be      = 4'b1111;
                illegal = (addr_lo != 2'b00);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule : mem_lane_decode
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares the single external RAM port between instruction
//                fetch (read-only, word) and data load/store. One access at a
//                time; alternating priority on ties; alignment checking;
//                ready timeout abort.
//  Ports       : clk, rst                - clock, sync active-high reset
//                if_req/if_addr/if_ack   - fetch requester handshake
//                d_req/d_we/d_addr/d_wdata/d_size/d_ack - data requester
//                rdata, err              - response, valid with an ack
//                cs/we/oe/address/ram_data_in/ram_be/ram_data_out/ram_ready
//                                        - RAM side
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        cs,
    output logic        we,
    output logic        oe,
    output logic [31:0] address,
    output logic [31:0] ram_data_in,
    output logic [3:0]  ram_be,
    input  logic [31:0] ram_data_out,
    input  logic        ram_ready
);

    // Last ACCESS cycle index before the abort
    localparam logic [CNT_W-1:0] c_CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic             r_owner;
    logic             r_last_grant;
    logic [1:0]       r_size;
    logic [1:0]       r_addr_lo;
    logic [CNT_W-1:0] r_cnt;

    logic             w_grant_data;
    logic [1:0]       w_sel_size;
    logic [31:0]      w_sel_addr;
    logic             w_sel_we;
    logic [1:0]       w_dec_size;
    logic [1:0]       w_dec_lo;
    logic [3:0]       w_be;
    logic             w_illegal;

    // Data wins when it is alone, or on a tie when fetch had the last grant.
    assign w_grant_data = d_req && (!if_req || (r_last_grant == OWN_FETCH));
    assign w_sel_size   = w_grant_data ? d_size : SZ_WORD;
    assign w_sel_addr   = w_grant_data ? d_addr : if_addr;
    assign w_sel_we     = w_grant_data & d_we;

    // In IDLE the decoder judges the candidate grant; afterwards it decodes
    // the latched fields so ram_be tracks the access in flight.
    assign w_dec_size = (r_state == ST_IDLE) ? w_sel_size      : r_size;
    assign w_dec_lo   = (r_state == ST_IDLE) ? w_sel_addr[1:0] : r_addr_lo;

    mem_lane_decode u_lane_decode (
        .size    (w_dec_size),
        .addr_lo (w_dec_lo),
        .be      (w_be),
        .illegal (w_illegal)
    );

    assign ram_be = cs ? w_be : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_FETCH;
            r_last_grant <= OWN_FETCH;
            r_size       <= SZ_BYTE;
            r_addr_lo    <= 2'b00;
            r_cnt        <= '0;
            if_ack       <= 1'b0;
            d_ack        <= 1'b0;
            err          <= 1'b0;
            rdata        <= 32'h0;
            cs           <= 1'b0;
            we           <= 1'b0;
            oe           <= 1'b0;
            address      <= 32'h0;
            ram_data_in  <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (if_req || d_req) begin
                        r_owner     <= w_grant_data ? OWN_DATA : OWN_FETCH;
                        r_size      <= w_sel_size;
                        r_addr_lo   <= w_sel_addr[1:0];
                        address     <= {w_sel_addr[31:2], 2'b00};
                        ram_data_in <= w_grant_data ? d_wdata : 32'h0;
                        if (w_illegal) begin
                            r_state <= ST_ERR;
                        end else begin
                            r_state <= ST_ACCESS;
                            cs      <= 1'b1;
                            we      <= w_sel_we;
                            oe      <= ~w_sel_we;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (ram_ready || (r_cnt == c_CNT_LIMIT)) begin
                        // Stores and timeouts return zero data.
                        rdata   <= (ram_ready && !we) ? ram_data_out : 32'h0;
                        err     <= ~ram_ready;
                        cs      <= 1'b0;
                        we      <= 1'b0;
                        oe      <= 1'b0;
                        if_ack  <= (r_owner == OWN_FETCH);
                        d_ack   <= (r_owner == OWN_DATA);
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_ERR: begin
                    rdata   <= 32'h0;
                    err     <= 1'b1;
                    if_ack  <= (r_owner == OWN_FETCH);
                    d_ack   <= (r_owner == OWN_DATA);
                    r_state <= ST_RESP;
                end
                default: begin
                    // RESP: the ack pulse is visible during this cycle.
                    if_ack       <= 1'b0;
                    d_ack        <= 1'b0;
                    err          <= 1'b0;
                    r_last_grant <= r_owner;
                    r_cnt        <= '0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Responses are
//                predicted into a scoreboard queue as requests are driven and
//                compared as acks appear. A small RAM model answers reads
//                with RD_BASE ^ address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int          TO      = 4;
    localparam logic [31:0] RD_BASE = 32'hE3A0_0101;

    typedef struct packed {
        logic        own;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [1:0]  d_size = 2'b10;
    logic        d_ack;
    logic [31:0] rdata;
    logic        err;
    logic        cs, we, oe;
    logic [31:0] address, ram_data_in, ram_data_out;
    logic [3:0]  ram_be;
    logic        ram_ready;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rdy_en   = 1'b1;
    int   cs_cnt   = 0;
    logic [31:0] cap_addr, cap_din;
    logic [3:0]  cap_be;
    logic        cap_we, cap_oe;
    exp_t sb[$];

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_ack(d_ack),
        .rdata(rdata), .err(err),
        .cs(cs), .we(we), .oe(oe), .address(address),
        .ram_data_in(ram_data_in), .ram_be(ram_be),
        .ram_data_out(ram_data_out), .ram_ready(ram_ready)
    );

    always #5 clk = ~clk;

    // RAM model: ready in the first cycle cs is seen, unless disabled.
    assign ram_ready    = cs & rdy_en;
    assign ram_data_out = cs ? (RD_BASE ^ address) : 32'h0;

    function automatic exp_t mk(input logic o, input logic [31:0] d, input logic e);
        mk = {o, d, e};
    endfunction

    // RAM-side capture and response scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (cs) begin
            cs_cnt   = cs_cnt + 1;
            cap_addr = address;
            cap_din  = ram_data_in;
            cap_be   = ram_be;
            cap_we   = we;
            cap_oe   = oe;
        end
        if (if_ack && d_ack) begin
            n_checks++; n_fail++;
            $display("FAIL dual_ack: if_ack=%b d_ack=%b, required at most one", if_ack, d_ack);
        end else if (if_ack || d_ack) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: if_ack=%b d_ack=%b with nothing outstanding", if_ack, d_ack);
            end else begin
                e = sb.pop_front();
                if ({d_ack, rdata, err} !== e) begin
                    n_fail++;
                    $display("FAIL response: got own=%b rdata=%h err=%b, required own=%b rdata=%h err=%b",
                             d_ack, rdata, err, e.own, e.rdata, e.err);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Steps at least one edge; returns edges until an ack is seen.
    task automatic wait_ack(output int edges);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!(if_ack || d_ack) && edges <= 40);
        if (!(if_ack || d_ack)) begin
            n_checks++; n_fail++;
            $display("FAIL ack_wait: no ack after %0d cycles", edges);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({cs, we, oe} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b, required 000", {cs, we, oe});
        end
        n_checks++;
        if ({if_ack, d_ack, err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ack: got %b, required 000", {if_ack, d_ack, err});
        end
        n_checks++;
        if ({address, ram_data_in, rdata} !== 96'h0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h, required zero", address, ram_data_in, rdata);
        end
        n_checks++;
        if (ram_be !== 4'b0000) begin
            n_fail++; $display("FAIL reset_be: got %b, required 0000", ram_be);
        end
    endtask

    task automatic test_fetch();
        int lat;
        rdy_en = 1'b1; cs_cnt = 0;
        if_addr = 32'h100; if_req = 1'b1;
        sb.push_back(mk(1'b0, 32'hE3A0_0001, 1'b0));
        wait_ack(lat);
        if_req = 1'b0;
        chk_int("fetch_latency", lat, 2);
        @(posedge clk); #1;
        n_checks++;
        if (if_ack !== 1'b0) begin
            n_fail++; $display("FAIL fetch_ack_pulse: got %b, required 0", if_ack);
        end
        chk_int("fetch_cs_cycles", cs_cnt, 1);
        n_checks++;
        if ({cap_addr, cap_be, cap_oe, cap_we} !== {32'h100, 4'b1111, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_ram: got addr=%h be=%b oe=%b we=%b, required 100 1111 1 0",
                     cap_addr, cap_be, cap_oe, cap_we);
        end
    endtask

    task automatic test_store_byte();
        int lat;
        rdy_en = 1'b1; cs_cnt = 0;
        d_we = 1'b1; d_size = 2'b00; d_addr = 32'h203; d_wdata = 32'hAB00_0000; d_req = 1'b1;
        sb.push_back(mk(1'b1, 32'h0, 1'b0));
        wait_ack(lat);
        d_req = 1'b0; d_we = 1'b0;
        chk_int("store_latency", lat, 2);
        @(posedge clk); #1;
        chk_int("store_cs_cycles", cs_cnt, 1);
        n_checks++;
        if ({cap_we, cap_oe, cap_addr, cap_be, cap_din} !== {1'b1, 1'b0, 32'h200, 4'b1000, 32'hAB00_0000}) begin
            n_fail++;
            $display("FAIL store_ram: got we=%b oe=%b addr=%h be=%b din=%h, required 1 0 200 1000 ab000000",
                     cap_we, cap_oe, cap_addr, cap_be, cap_din);
        end
    endtask

    // Table: {is_data, size, addr, expect_err, expected be when legal}
    task automatic test_alignment();
        logic        t_data [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0]  t_size [4] = '{2'b01, 2'b11, 2'b10, 2'b01};
        logic [31:0] t_addr [4] = '{32'h201, 32'h200, 32'h102, 32'h202};
        logic        t_err  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  t_be   [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1100};
        int lat;
        rdy_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cs_cnt = 0;
            d_we = 1'b0; d_size = t_size[i];
            if (t_data[i]) begin d_addr = t_addr[i]; d_req = 1'b1; end
            else begin if_addr = t_addr[i]; if_req = 1'b1; end
            sb.push_back(mk(t_data[i], t_err[i] ? 32'h0 : (RD_BASE ^ {t_addr[i][31:2], 2'b00}), t_err[i]));
            wait_ack(lat);
            d_req = 1'b0; if_req = 1'b0;
            chk_int($sformatf("align%0d_latency", i), lat, 2);
            @(posedge clk); #1;
            chk_int($sformatf("align%0d_cs_cycles", i), cs_cnt, t_err[i] ? 0 : 1);
            if (!t_err[i]) begin
                n_checks++;
                if (cap_be !== t_be[i]) begin
                    n_fail++; $display("FAIL align%0d_be: got %b, required %b", i, cap_be, t_be[i]);
                end
            end
        end
        d_size = 2'b10;
    endtask

    task automatic test_timeout();
        int lat;
        rdy_en = 1'b0; cs_cnt = 0;
        if_addr = 32'h300; if_req = 1'b1;
        sb.push_back(mk(1'b0, 32'h0, 1'b1));
        wait_ack(lat);
        if_req = 1'b0;
        chk_int("timeout_latency", lat, TO + 1);
        chk_int("timeout_cs_cycles", cs_cnt, TO);
        rdy_en = 1'b1;
        @(posedge clk); #1;
        cs_cnt = 0;
        d_we = 1'b0; d_size = 2'b10; d_addr = 32'h204; d_req = 1'b1;
        sb.push_back(mk(1'b1, RD_BASE ^ 32'h204, 1'b0));
        wait_ack(lat);
        d_req = 1'b0;
        chk_int("after_timeout_latency", lat, 2);
        @(posedge clk); #1;
        chk_int("after_timeout_cs_cycles", cs_cnt, 1);
    endtask

    task automatic test_reset_mid();
        int lat;
        rdy_en = 1'b0;
        d_we = 1'b0; d_size = 2'b10; d_addr = 32'h208; d_req = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (cs !== 1'b1) begin
            n_fail++; $display("FAIL midrst_access: cs got %b, required 1", cs);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        d_req = 1'b0;
        n_checks++;
        if ({cs, we, oe, if_ack, d_ack, err, ram_be, address, ram_data_in, rdata} !== 106'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: cs=%b we=%b oe=%b ack=%b%b err=%b be=%b addr=%h din=%h rdata=%h, required all zero",
                     cs, we, oe, if_ack, d_ack, err, ram_be, address, ram_data_in, rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rdy_en = 1'b1; cs_cnt = 0;
        d_req = 1'b1;
        sb.push_back(mk(1'b1, RD_BASE ^ 32'h208, 1'b0));
        wait_ack(lat);
        d_req = 1'b0;
        chk_int("midrst_retry_latency", lat, 2);
        @(posedge clk); #1;
    endtask

    // Both requesters held continuously: grants alternate, 3 cycles each.
    task automatic test_back_to_back();
        int lat;
        do_reset();
        rdy_en = 1'b1; cs_cnt = 0;
        if_addr = 32'h104;
        d_we = 1'b0; d_size = 2'b10; d_addr = 32'h200;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(1'b1, RD_BASE ^ 32'h200, 1'b0));
            sb.push_back(mk(1'b0, RD_BASE ^ 32'h104, 1'b0));
        end
        if_req = 1'b1; d_req = 1'b1;
        wait_ack(lat);
        chk_int("b2b_first_latency", lat, 2);
        for (int i = 1; i < 4; i++) begin
            wait_ack(lat);
            chk_int($sformatf("b2b_gap%0d", i), lat, 3);
        end
        if_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        chk_int("b2b_cs_cycles", cs_cnt, 4);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_byte();
        test_alignment();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        chk_int("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
